// File: rtl/trig_enc_sched_if.sv
// rtl/trig_enc_sched_if.sv - control/data bundle between the L1A scheduler and the CFEB trigger encoder
interface trig_enc_sched_if #(
   parameter int DEPTH = 16
);
   logic                   ENCODE_EN;
   logic                   DCFEB_EN;
   logic                   L1A_IN;
   logic [5:1]             L1A_MATCH_IN;
   logic [5:1]             MTCH_WIN_IN;
   logic [5:1]             PRE_LCT_IN;
   logic                   RESYNC_REQ;

   logic                   ENCODE;
   logic                   DCFEB_IN_USE;
   logic                   SND_WIN;
   logic                   RESYNC_RST;
   logic                   L1ACFEB;
   logic [5:1]             L1A_MATCH;
   logic [5:1]             MTCH_WIN_0;
   logic [5:1]             PRE_LCT_OUT;
   logic [$clog2(DEPTH):0] L1A_PEND;
   logic                   L1A_OVFL;

   modport master (
      output ENCODE_EN, DCFEB_EN, L1A_IN, L1A_MATCH_IN, MTCH_WIN_IN, PRE_LCT_IN, RESYNC_REQ,
      input  ENCODE, DCFEB_IN_USE, SND_WIN, RESYNC_RST, L1ACFEB, L1A_MATCH, MTCH_WIN_0,
             PRE_LCT_OUT, L1A_PEND, L1A_OVFL
   );

   modport slave (
      input  ENCODE_EN, DCFEB_EN, L1A_IN, L1A_MATCH_IN, MTCH_WIN_IN, PRE_LCT_IN, RESYNC_REQ,
      output ENCODE, DCFEB_IN_USE, SND_WIN, RESYNC_RST, L1ACFEB, L1A_MATCH, MTCH_WIN_0,
             PRE_LCT_OUT, L1A_PEND, L1A_OVFL
   );
endinterface

// File: rtl/trig_enc_sched.sv
// rtl/trig_enc_sched.sv - L1A queue, slot scheduler, resync stretcher and mode latch for the CFEB encoder
module trig_enc_sched_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_ok;
   logic             rd_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign wr_ok   = wr_en && !full && !flush;
   assign rd_ok   = rd_en && !empty && !flush;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module trig_enc_sched #(
   parameter int DEPTH      = 16,
   parameter int RESYNC_LEN = 4
) (
   input  logic            CLK,
   input  logic            RST,
   trig_enc_sched_if.slave bus
);
   localparam int CW = (RESYNC_LEN > 1) ? $clog2(RESYNC_LEN) : 1;
   localparam logic [CW-1:0] RS_LOAD = CW'(RESYNC_LEN - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ISSUE  = 2'd1;
   localparam logic [1:0] S_TAIL   = 2'd2;
   localparam logic [1:0] S_RESYNC = 2'd3;

   logic [1:0]           state;
   logic [1:0]           state_nxt;
   logic [CW-1:0]        rs_cnt;
   logic [9:0]           head;
   logic [$clog2(DEPTH):0] count;
   logic                 full;
   logic                 empty;
   logic                 take_l1a;
   logic                 wr_en;
   logic                 rd_en;
   logic [5:1]           win_hold;
   logic [5:1]           pre_lct_d1;
   logic                 pre_block;

   // L1As arriving while a resync is requested or being stretched never reach the queue
   assign take_l1a  = bus.L1A_IN && !bus.RESYNC_REQ && (state != S_RESYNC);
   assign wr_en     = take_l1a && !full;
   assign rd_en     = !bus.RESYNC_REQ && !empty && ((state == S_IDLE) || (state == S_TAIL));
   assign pre_block = bus.RESYNC_REQ || (state == S_RESYNC);

   trig_enc_sched_fifo #(.DEPTH(DEPTH), .WIDTH(10)) u_fifo (
      .clk     (CLK),
      .rst     (RST),
      .flush   (bus.RESYNC_REQ),
      .wr_en   (wr_en),
      .wr_data ({bus.MTCH_WIN_IN, bus.L1A_MATCH_IN}),
      .rd_en   (rd_en),
      .rd_data (head),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   assign bus.L1A_PEND = count;

   always_comb begin
      state_nxt = state;
      if (bus.RESYNC_REQ) begin
         state_nxt = S_RESYNC;
      end else begin
         case (state)
            S_IDLE:  if (!empty) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_TAIL;
            S_TAIL:  state_nxt = empty ? S_IDLE : S_ISSUE;
            default: if (rs_cnt == '0) state_nxt = S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so each one lines up with its own state cycle
   always_ff @(posedge CLK) begin
      if (RST) begin
         state            <= S_IDLE;
         rs_cnt           <= '0;
         win_hold         <= '0;
         bus.L1ACFEB      <= 1'b0;
         bus.L1A_MATCH    <= '0;
         bus.SND_WIN      <= 1'b0;
         bus.MTCH_WIN_0   <= '0;
         bus.RESYNC_RST   <= 1'b0;
         bus.L1A_OVFL     <= 1'b0;
         bus.ENCODE       <= 1'b0;
         bus.DCFEB_IN_USE <= 1'b0;
      end else begin
         state          <= state_nxt;
         bus.L1ACFEB    <= (state_nxt == S_ISSUE);
         bus.L1A_MATCH  <= (state_nxt == S_ISSUE) ? head[4:0] : 5'b0;
         bus.SND_WIN    <= (state_nxt == S_TAIL) && bus.DCFEB_IN_USE;
         bus.MTCH_WIN_0 <= ((state_nxt == S_TAIL) && bus.DCFEB_IN_USE) ? win_hold : 5'b0;
         bus.RESYNC_RST <= (state_nxt == S_RESYNC);

         if (state_nxt == S_ISSUE) win_hold <= head[9:5];

         if (bus.RESYNC_REQ)
            rs_cnt <= RS_LOAD;
         else if ((state == S_RESYNC) && (rs_cnt != '0))
            rs_cnt <= rs_cnt - 1'b1;

         // Full is judged on the occupancy at the start of the cycle, a same-cycle pop does not help
         if (take_l1a && full) bus.L1A_OVFL <= 1'b1;

         if ((state == S_IDLE) && empty && !bus.RESYNC_REQ) begin
            bus.ENCODE       <= bus.ENCODE_EN;
            bus.DCFEB_IN_USE <= bus.DCFEB_EN;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST || pre_block) begin
         pre_lct_d1      <= '0;
         bus.PRE_LCT_OUT <= '0;
      end else begin
         pre_lct_d1      <= bus.PRE_LCT_IN;
         bus.PRE_LCT_OUT <= pre_lct_d1;
      end
   end
endmodule

// File: tb/tb_trig_enc_sched.sv
// tb/tb_trig_enc_sched.sv - directed and randomized bench for trig_enc_sched against a slot-level model
module tb_trig_enc_sched;
   localparam int DEPTH = 16;
   localparam int RLEN  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   trig_enc_sched_if #(.DEPTH(DEPTH)) bus ();

   trig_enc_sched #(.DEPTH(DEPTH), .RESYNC_LEN(RLEN)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   int n_chk, n_pass, n_fail;

   // Model: pending entries, edge of the last issue, edge of the last resync request
   logic [9:0] q[$];
   int         t, last_issue, rs_start, accepted;
   logic       last_tail, prev_blocked, m_enc, m_dcfeb, m_ovfl;
   logic [4:0] hold_win, prev_pl;
   logic       e_l1a, e_snd, e_rst;
   logic [4:0] e_match, e_win, e_pl;

   int pulses, peak;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      last_issue   = -100;
      rs_start     = -100;
      last_tail    = 1'b0;
      prev_blocked = 1'b1;
      prev_pl      = '0;
      m_enc        = 1'b0;
      m_dcfeb      = 1'b0;
      m_ovfl       = 1'b0;
      hold_win     = '0;
      e_l1a = 1'b0; e_snd = 1'b0; e_rst = 1'b0;
      e_match = '0; e_win = '0; e_pl = '0;
   endtask

   task automatic model_step();
      logic       req, in_rs, blocked, idle, issue, tail;
      int         cnt;
      logic [9:0] ent;
      t++;
      if (rst) begin
         model_clear();
         return;
      end
      req     = bus.RESYNC_REQ;
      in_rs   = (t > rs_start) && (t <= rs_start + RLEN);
      blocked = req || in_rs;
      cnt     = q.size();
      idle    = (last_issue != t - 1) && !last_tail && !in_rs;
      issue   = !req && !in_rs && (cnt > 0) && (t >= last_issue + 2);
      tail    = !req && (last_issue == t - 1);
      e_snd   = tail && m_dcfeb;
      e_win   = e_snd ? hold_win : 5'b0;
      e_l1a   = issue;
      e_match = '0;
      if (idle && cnt == 0 && !req) begin
         m_enc   = bus.ENCODE_EN;
         m_dcfeb = bus.DCFEB_EN;
      end
      if (req) begin
         q.delete();
         rs_start = t;
      end else begin
         if (issue) begin
            ent        = q.pop_front();
            e_match    = ent[4:0];
            hold_win   = ent[9:5];
            last_issue = t;
         end
         if (bus.L1A_IN && !in_rs) begin
            if (cnt == DEPTH) m_ovfl = 1'b1;
            else begin
               q.push_back({bus.MTCH_WIN_IN, bus.L1A_MATCH_IN});
               accepted++;
            end
         end
      end
      last_tail    = tail;
      e_rst        = (t >= rs_start) && (t < rs_start + RLEN);
      e_pl         = (blocked || prev_blocked) ? 5'b0 : prev_pl;
      prev_pl      = bus.PRE_LCT_IN;
      prev_blocked = blocked;
   endtask

   task automatic check_all();
      chk("l1acfeb",      bus.L1ACFEB,      e_l1a);
      chk("l1a_match",    bus.L1A_MATCH,    e_match);
      chk("snd_win",      bus.SND_WIN,      e_snd);
      chk("mtch_win_0",   bus.MTCH_WIN_0,   e_win);
      chk("resync_rst",   bus.RESYNC_RST,   e_rst);
      chk("pre_lct_out",  bus.PRE_LCT_OUT,  e_pl);
      chk("encode",       bus.ENCODE,       m_enc);
      chk("dcfeb_in_use", bus.DCFEB_IN_USE, m_dcfeb);
      chk("l1a_pend",     bus.L1A_PEND,     q.size());
      chk("l1a_ovfl",     bus.L1A_OVFL,     m_ovfl);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
      if (bus.L1ACFEB) pulses++;
      if (int'(bus.L1A_PEND) > peak) peak = int'(bus.L1A_PEND);
   endtask

   task automatic drive(input logic l1a, input logic [4:0] m, input logic [4:0] w,
                        input logic [4:0] p, input logic rq);
      bus.L1A_IN       = l1a;
      bus.L1A_MATCH_IN = m;
      bus.MTCH_WIN_IN  = w;
      bus.PRE_LCT_IN   = p;
      bus.RESYNC_REQ   = rq;
   endtask

   initial begin
      int p0, a0, rst_cycles;
      logic any_pre;
      n_chk = 0; n_pass = 0; n_fail = 0;
      t = 0; accepted = 0; pulses = 0; peak = 0;
      model_clear();
      drive(1'b0, '0, '0, '0, 1'b0);
      bus.ENCODE_EN = 1'b0;
      bus.DCFEB_EN  = 1'b0;

      rst = 1'b1;
      repeat (3) tick();
      chk("reset_pend", bus.L1A_PEND, 0);
      rst = 1'b0;

      // single L1A in DCFEB mode
      bus.DCFEB_EN = 1'b1;
      repeat (2) tick();
      drive(1'b1, 5'b10101, 5'b01010, '0, 1'b0);
      tick();
      drive(1'b0, '0, '0, '0, 1'b0);
      tick();
      chk("t1_l1acfeb", bus.L1ACFEB, 1);
      chk("t1_match", bus.L1A_MATCH, 5'b10101);
      tick();
      chk("t1_snd_win", bus.SND_WIN, 1);
      chk("t1_win", bus.MTCH_WIN_0, 5'b01010);
      chk("t1_l1acfeb_off", bus.L1ACFEB, 0);
      repeat (3) begin
         tick();
         chk("t1_quiet", {bus.L1ACFEB, bus.L1A_MATCH, bus.SND_WIN, bus.MTCH_WIN_0, bus.RESYNC_RST,
                          bus.PRE_LCT_OUT, bus.L1A_PEND, bus.L1A_OVFL}, 0);
      end

      // L1A and resync in the same cycle
      p0 = pulses;
      drive(1'b1, 5'b11111, 5'b11111, '0, 1'b1);
      tick();
      drive(1'b0, '0, '0, '0, 1'b0);
      repeat (RLEN + 4) tick();
      chk("same_no_issue", pulses - p0, 0);
      chk("same_ovfl", bus.L1A_OVFL, 0);

      // pre-LCT delay, then the same stimulus inside a resync
      drive(1'b0, '0, '0, 5'b00011, 1'b0);
      tick();
      drive(1'b0, '0, '0, '0, 1'b0);
      tick();
      chk("pre_out", bus.PRE_LCT_OUT, 5'b00011);
      tick();
      chk("pre_out_gone", bus.PRE_LCT_OUT, 0);
      drive(1'b0, '0, '0, '0, 1'b1);
      tick();
      drive(1'b0, '0, '0, 5'b00011, 1'b0);
      tick();
      drive(1'b0, '0, '0, '0, 1'b0);
      any_pre = 1'b0;
      repeat (RLEN + 2) begin
         tick();
         any_pre = any_pre | (bus.PRE_LCT_OUT != '0);
      end
      chk("pre_in_resync", any_pre, 0);
      repeat (4) tick();

      // mode change while 3 entries are pending
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 5'($urandom), 5'($urandom), '0, 1'b0);
         tick();
      end
      chk("enc_pend3", bus.L1A_PEND, 3);
      drive(1'b0, '0, '0, '0, 1'b0);
      bus.ENCODE_EN = 1'b1;
      for (int j = 5; j < 15; j++) begin
         tick();
         chk("enc_latch", bus.ENCODE, (j >= 12));
      end

      // resync with 5 entries queued
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 5'($urandom), 5'($urandom), '0, 1'b0);
         tick();
      end
      chk("rs_pend5", bus.L1A_PEND, 5);
      drive(1'b0, '0, '0, '0, 1'b1);
      p0 = pulses;
      tick();
      chk("rs_pend0", bus.L1A_PEND, 0);
      rst_cycles = int'(bus.RESYNC_RST);
      drive(1'b0, '0, '0, '0, 1'b0);
      repeat (12) begin
         tick();
         rst_cycles += int'(bus.RESYNC_RST);
      end
      chk("rs_len", rst_cycles, RLEN);
      chk("rs_no_issue", pulses - p0, 0);

      // 40 back-to-back L1As overflow the queue
      p0 = pulses; a0 = accepted; peak = 0;
      for (int i = 0; i < 40; i++) begin
         drive(1'b1, 5'($urandom), 5'($urandom), '0, 1'b0);
         tick();
      end
      drive(1'b0, '0, '0, '0, 1'b0);
      repeat (40) tick();
      chk("burst_peak", peak, DEPTH);
      chk("burst_ovfl", bus.L1A_OVFL, 1);
      chk("burst_issued_eq_accepted", pulses - p0, accepted - a0);
      chk("burst_issued", pulses - p0, 35);

      // randomized traffic with occasional resyncs, mode requests and one reset
      for (int i = 0; i < 800; i++) begin
         drive(1'($urandom_range(0, 2) != 0), 5'($urandom), 5'($urandom), 5'($urandom),
               1'($urandom_range(0, 39) == 0));
         if ($urandom_range(0, 19) == 0) bus.ENCODE_EN = 1'($urandom);
         if ($urandom_range(0, 19) == 0) bus.DCFEB_EN  = 1'($urandom);
         rst = (i == 400);
         tick();
      end
      rst = 1'b0;
      drive(1'b0, '0, '0, '0, 1'b0);
      repeat (40) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
